_register_pipe_r: RTL

Parametrised pipeline register chain with a valid/ready handshake on both sides. It is the WIDTH-generic, DEPTH-generic successor of the fixed 3-bit resettable register. Each stage is an asynchronously reset register with a valid bit. It adds backpressure, bubble collapsing, synchronous flush and an occupancy count. It sits between controller stages that must not lose or duplicate state words, for example between the traffic-light next-state logic and the output-decode stage.

---
 rtl/_register_pipe_r.sv | 79 +++++++
 1 files changed

// File: rtl/_register_pipe_r.sv
// Parametrised valid/ready pipeline register chain with bubble collapsing,
// synchronous flush and occupancy count; stage DEPTH-1 drives the output.
module _register_pipe_r #(
    parameter int unsigned       WIDTH     = 3,
    parameter int unsigned       DEPTH     = 2,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]             r_v;
    logic [DEPTH-1:0][WIDTH-1:0]  r_d;
    logic [DEPTH-1:0]             w_v_nxt;
    logic [DEPTH-1:0][WIDTH-1:0]  w_d_nxt;
    logic [DEPTH-1:0]             w_rdy;
    logic [CW-1:0]                w_count;

    // rdy[k] unrolled: stage k can load if any stage at or after k is empty,
    // or the output is being taken this cycle.
    always_comb begin
        w_rdy = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_rdy[k] = out_ready;
            for (int unsigned j = k; j < DEPTH; j++) begin
                if (!r_v[j]) w_rdy[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_v_nxt = r_v;
        w_d_nxt = r_d;
        if (w_rdy[0]) begin
            w_v_nxt[0] = in_valid;
            if (in_valid && !flush) w_d_nxt[0] = in_data;
        end
        for (int unsigned k = 1; k < DEPTH; k++) begin
            if (w_rdy[k]) begin
                w_v_nxt[k] = r_v[k-1];
                if (r_v[k-1] && !flush) w_d_nxt[k] = r_d[k-1];
            end
        end
        if (flush) w_v_nxt = '0;
    end

    always_comb begin
        w_count = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_count = w_count + CW'(r_v[k]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v <= '0;
            r_d <= {DEPTH{RESET_VAL}};
        end else begin
            r_v <= w_v_nxt;
            r_d <= w_d_nxt;
        end
    end

    assign in_ready  = w_rdy[0] & ~flush;
    assign out_valid = r_v[DEPTH-1];
    assign out_data  = r_d[DEPTH-1];
    assign count     = w_count;

endmodule
